// File: rtl/dp_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_param
// Purpose  : Single-clock simple dual-port RAM (one write port, one read
//            port) with a self-clearing sweep, configurable read latency
//            and configurable same-address read-during-write behaviour.
//
// Ports    :
//   clk        in   1       single clock, all state changes on rising edge
//   rst        in   1       asynchronous active-high reset
//   din        in   DATA_W  write data
//   wr_addr    in   ADDR_W  write address
//   we         in   1       write enable
//   re         in   1       read enable
//   re_addr    in   ADDR_W  read address
//   clr        in   1       request to zero the whole array
//   d_out      out  DATA_W  read data (holds when rd_valid = 0)
//   rd_valid   out  1       d_out carries data of a read RD_LAT cycles old
//   busy       out  1       clear sweep in progress, requests ignored
//   collision  out  1       accepted read and write hit the same address,
//                           aligned with that read's rd_valid
//
// Parameters:
//   DATA_W    data word width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   RD_LAT    read latency, 1 or 2 (any value other than 1 builds latency 2)
//   RDW_MODE  0 = read-old, 1 = write-first on same-address collisions
//
// Revision : 1.0  initial release
// ============================================================================
module dp_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] re_addr,
  input  logic              clr,
  output logic [DATA_W-1:0] d_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  // Storage array: deliberately has no reset; the sweep zeroes it.
  logic [DATA_W-1:0] mem [DEPTH];

  // Request qualification. Nothing is accepted during the sweep. A write
  // coinciding with a clear request is dropped, but a read on that edge is
  // still accepted and completes with the pre-clear contents.
  logic              rd_acc;
  logic              wr_acc;
  logic              same_addr;
  logic [DATA_W-1:0] rd_data;

  assign rd_acc    = (state == READY) && re;
  assign wr_acc    = (state == READY) && we && !clr;
  assign same_addr = rd_acc && wr_acc && (re_addr == wr_addr);

  // --------------------------------------------------------------------------
  // Control FSM: CLEAR sweeps every address once, READY serves requests.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr) begin
            // Restart the sweep from address 0.
            clr_cnt <= '0;
          end else if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            // Last address is zeroed on this edge.
            state   <= READY;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          busy    <= 1'b1;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Single write port shared between the sweep and user writes. The two
  // never compete because user writes are only accepted in READY.
  // --------------------------------------------------------------------------
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = din;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read-during-write selection. The array read is the pre-edge content, so
  // read-old needs nothing extra; write-first forwards din on a hit.
  // --------------------------------------------------------------------------
  generate
    if (RDW_MODE != 0) begin : g_rdw_write_first
      assign rd_data = same_addr ? din : mem[re_addr];
    end else begin : g_rdw_read_old
      assign rd_data = mem[re_addr];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read output path. d_out only loads with a valid read so it holds its
  // last value otherwise; collision travels alongside its read.
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_out     <= '0;
          rd_valid  <= 1'b0;
          collision <= 1'b0;
        end else begin
          rd_valid  <= rd_acc;
          collision <= same_addr;
          if (rd_acc) begin
            d_out <= rd_data;
          end
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] pipe_data;
      logic              pipe_valid;
      logic              pipe_coll;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_data  <= '0;
          pipe_valid <= 1'b0;
          pipe_coll  <= 1'b0;
          d_out      <= '0;
          rd_valid   <= 1'b0;
          collision  <= 1'b0;
        end else begin
          // Stage 1: array sampled at the accept edge.
          pipe_valid <= rd_acc;
          pipe_coll  <= same_addr;
          if (rd_acc) begin
            pipe_data <= rd_data;
          end
          // Stage 2: presented one edge later.
          rd_valid  <= pipe_valid;
          collision <= pipe_coll;
          if (pipe_valid) begin
            d_out <= pipe_data;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/dp_ram_param.md
DP_RAM_PARAM -- requirements
Module: dp_ram_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2 only.
REQ-004 Parameter RDW_MODE, default 0: same-address read-during-write; 0 = read-old, 1 = write-first (bypass).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 din  input  DATA_W  write data.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 we  input  1  write enable.
REQ-010 re  input  1  read enable.
REQ-011 re_addr  input  ADDR_W  read address.
REQ-012 clr  input  1  request to zero the whole array.
REQ-013 d_out  output  DATA_W  read data.
REQ-014 rd_valid  output  1  d_out carries the data of a read accepted RD_LAT cycles earlier.
REQ-015 busy  output  1  clear sweep in progress; requests are ignored.
REQ-016 collision  output  1  one-cycle flag: an accepted read and write used the same address.

Function
REQ-017 FSM states: CLEAR and READY.
  - CLEAR: a DEPTH-cycle zeroing sweep; busy = 1.
  - READY: normal operation; busy = 0.
REQ-018 CLEAR sweep.
  - Each cycle writes 0 to mem[clr_cnt], then increments clr_cnt.
  - After the cycle that writes address DEPTH-1, the FSM enters READY on the next edge.
  - busy is high for exactly DEPTH cycles.
REQ-019 In READY, clr = 1 at an edge sets clr_cnt = 0 and enters CLEAR; a write on that same edge is discarded.
REQ-020 clr = 1 while in CLEAR restarts the sweep: clr_cnt = 0.
REQ-021 In READY, we = 1 writes din to mem[wr_addr] at the edge.
REQ-022 While busy = 1, we and re are ignored: no write, no read accepted, no collision.
REQ-023 Read acceptance and timing.
  - A read is accepted when re = 1 in READY.
  - The array is sampled at the accept edge.
  - RD_LAT = 1: d_out and rd_valid update on that same edge.
  - RD_LAT = 2: d_out and rd_valid update one edge later, through one pipeline register.
REQ-024 rd_valid is 1 for exactly one cycle per accepted read; back-to-back reads produce back-to-back valids with no bubbles.
REQ-025 d_out holds its last value when rd_valid = 0.
REQ-026 A read accepted on the cycle READY is re-entered into CLEAR still completes normally, with its data sampled at acceptance.
REQ-027 Same-address read and write on one edge (wr_addr == re_addr, both accepted):
  - RDW_MODE = 0: d_out returns the prior mem contents.
  - RDW_MODE = 1: d_out returns din.
  - Either mode: the write completes and collision = 1 aligned with that read's rd_valid.
REQ-028 Different-address simultaneous read and write: both complete independently; collision = 0.
REQ-029 Addresses are ADDR_W bits wide with no bounds check; the full DEPTH range is usable.
REQ-030 Array contents are undefined until the first sweep completes; no RDW hazard exists against the sweep because reads are blocked.

Reset
REQ-031 While rst = 1, regardless of clk:
  - d_out = 0, rd_valid = 0, collision = 0;
  - read pipeline cleared;
  - clr_cnt = 0;
  - FSM = CLEAR, so busy = 1.
REQ-032 The array itself is not asynchronously reset; the CLEAR sweep after rst deasserts zeroes it.
REQ-033 rst asserted mid-sweep or mid-read aborts all in-flight activity; no rd_valid is produced for reads pending at assertion.

Verification
REQ-034 Reset release, default parameters -> busy = 1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x00 with rd_valid.
REQ-035 Write 0xA5 at address 4'hA, then read 4'hA -> d_out = 0xA5; rd_valid after 1 cycle (RD_LAT = 1) or 2 cycles (RD_LAT = 2).
REQ-036 mem[3] = 0x11; same edge we = 1, din = 0x22 at address 3 and re = 1 at address 3 ->
  - RDW_MODE = 0: d_out = 0x11.
  - RDW_MODE = 1: d_out = 0x22.
  - Both modes: collision = 1; a later read of address 3 returns 0x22.
REQ-037 clr pulse in READY with nonzero contents; pulse clr again at sweep cycle 5 -> busy lasts 5 + 16 cycles; all words read back 0; we/re during busy have no effect.
REQ-038 rst asserted asynchronously between clock edges during a RD_LAT = 2 read burst -> outputs immediately zero, no stray rd_valid, and a full 16-cycle sweep follows release.
REQ-039 Parameter sweep DATA_W = 16, ADDR_W = 6 -> 64-cycle busy; write/read checks pass at addresses 0 and 63.
